// File: rtl/core_pkg.sv
// Shared core definitions: load/store requester indices and the packet
// types carried by ldst_if.
package core_pkg;

    localparam int LDST_REQ_IFU = 0;
    localparam int LDST_REQ_LSU = 1;
    localparam int LDST_N_REQ   = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
    } ldst_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } ldst_rsp_t;

endpackage

// File: rtl/ldst_if.sv
// Load/store request/response channel with independent valid/ready handshakes.
// The master issues requests and accepts responses.
interface ldst_if;
    import core_pkg::*;

    logic      req_vld;
    ldst_req_t req_pkt;
    logic      req_rdy;
    logic      rsp_vld;
    ldst_rsp_t rsp_pkt;
    logic      rsp_rdy;

    modport master (
        output req_vld, req_pkt, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_pkt
    );

    modport slave (
        input  req_vld, req_pkt, rsp_rdy,
        output req_rdy, rsp_vld, rsp_pkt
    );

endinterface

// File: rtl/ldst_arb_tag_fifo.sv
// In-order FIFO of requester tags for outstanding downstream requests.
// Push and pop in the same cycle keep the count and advance both pointers.
module ldst_arb_tag_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: the storage array has no reset; an entry is only read once count says it was written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ldst_arb.sv
// Round-robin arbiter of N load/store requesters onto one downstream port;
// responses are routed back in order through a tag FIFO.
module ldst_arb
    import core_pkg::*;
#(
    parameter int N_REQ           = LDST_N_REQ,
    parameter int MAX_OUTSTANDING = 4,
    parameter int IDX_W           = $clog2(N_REQ)
) (
    input  logic   clk,
    input  logic   rst,
    ldst_if.slave  ldst_src [N_REQ],
    ldst_if.master ldst_gen
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First valid requester at or after ptr, wrapping modulo N_REQ.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] vld,
                                      input logic [IDX_W-1:0] ptr);
        pick_t            res;
        int               sum;
        logic [IDX_W-1:0] cand;
        res = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = int'(ptr) + k;
            if (sum >= N_REQ) begin
                sum = sum - N_REQ;
            end
            cand = IDX_W'(sum);
            if (!res.hit && vld[cand]) begin
                res.hit = 1'b1;
                res.idx = cand;
            end
        end
        return res;
    endfunction

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    logic [N_REQ-1:0] src_req_vld;
    ldst_req_t        src_req_pkt [N_REQ];
    logic [N_REQ-1:0] src_req_rdy;
    logic [N_REQ-1:0] src_rsp_vld;
    logic [N_REQ-1:0] src_rsp_rdy;

    logic             gen_req_vld;
    logic             gen_req_rdy;
    logic             gen_rsp_vld;
    logic             gen_rsp_rdy;

    logic [IDX_W-1:0] rr_ptr;
    logic             lock_vld;
    logic [IDX_W-1:0] lock_idx;

    pick_t            pick;
    logic             has_grant;
    logic [IDX_W-1:0] grant;
    logic             can_issue;
    logic             req_fire;
    logic             rsp_fire;

    logic [IDX_W-1:0] tag_head;
    logic             tag_full;
    logic             tag_empty;
    logic [CNT_W-1:0] tag_count;

    for (genvar g = 0; g < N_REQ; g++) begin : g_src
        assign src_req_vld[g]     = ldst_src[g].req_vld;
        assign src_req_pkt[g]     = ldst_src[g].req_pkt;
        assign src_rsp_rdy[g]     = ldst_src[g].rsp_rdy;
        assign ldst_src[g].req_rdy = src_req_rdy[g];
        assign ldst_src[g].rsp_vld = src_rsp_vld[g];
        assign ldst_src[g].rsp_pkt = ldst_gen.rsp_pkt;
    end

    assign gen_req_rdy      = ldst_gen.req_rdy;
    assign gen_rsp_vld      = ldst_gen.rsp_vld;
    assign ldst_gen.req_vld = gen_req_vld;
    assign ldst_gen.req_pkt = src_req_pkt[grant];
    assign ldst_gen.rsp_rdy = gen_rsp_rdy;

    // A slot freed by a response this cycle is only reusable next cycle.
    assign can_issue = (tag_count < CNT_W'(MAX_OUTSTANDING));
    assign req_fire  = gen_req_vld && gen_req_rdy;
    assign rsp_fire  = gen_rsp_vld && gen_rsp_rdy;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        pick        = rr_pick(src_req_vld, rr_ptr);
        has_grant   = pick.hit;
        grant       = pick.idx;
        src_req_rdy = '0;
        if (lock_vld) begin
            has_grant = 1'b1;
            grant     = lock_idx;
        end
        gen_req_vld = !rst && can_issue && has_grant && src_req_vld[grant];
        if (!rst && has_grant && can_issue && gen_req_rdy) begin
            src_req_rdy[grant] = 1'b1;
        end
    end

    // Responses go to the oldest outstanding owner; nothing is routed when empty.
    always_comb begin
        src_rsp_vld = '0;
        gen_rsp_rdy = 1'b0;
        if (!tag_empty) begin
            src_rsp_vld[tag_head] = gen_rsp_vld;
            gen_rsp_rdy           = src_rsp_rdy[tag_head];
        end
    end

    ldst_arb_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .W     (IDX_W)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_fire),
        .push_data (grant),
        .pop       (rsp_fire),
        .pop_data  (tag_head),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (tag_count)
    );

    // The lock pins the grant while the downstream stalls a presented request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            lock_vld <= 1'b0;
            lock_idx <= '0;
        end else begin
            if (req_fire) begin
                rr_ptr   <= idx_inc(grant);
                lock_vld <= 1'b0;
            end else if (gen_req_vld) begin
                lock_vld <= 1'b1;
                lock_idx <= grant;
            end
        end
    end

    a_no_rsp_when_idle: assert property (@(posedge clk) disable iff (rst)
        !(gen_rsp_vld && tag_empty))
        else $error("ldst_arb: downstream response with no outstanding request");

    a_no_issue_when_full: assert property (@(posedge clk) disable iff (rst)
        !(req_fire && tag_full))
        else $error("ldst_arb: request issued with tag FIFO full");

endmodule

// File: tb/tb_ldst_arb.sv
// Randomized bench for ldst_arb: a reference arbiter model checks each grant,
// and a scoreboard of expected responses checks routing and data.
module tb_ldst_arb;
    import core_pkg::*;

    localparam int N_REQ   = 2;
    localparam int MAX_OUT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ldst_if src_if [N_REQ] ();
    ldst_if gen_if ();

    ldst_arb #(
        .N_REQ           (N_REQ),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ldst_src (src_if),
        .ldst_gen (gen_if)
    );

    logic [N_REQ-1:0] s_vld;
    logic [N_REQ-1:0] s_rdy;
    logic [N_REQ-1:0] s_rsp_vld;
    logic [N_REQ-1:0] s_rsp_rdy;
    ldst_req_t        s_pkt     [N_REQ];
    ldst_rsp_t        s_rsp_pkt [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_src
        assign src_if[g].req_vld = s_vld[g];
        assign src_if[g].req_pkt = s_pkt[g];
        assign src_if[g].rsp_rdy = s_rsp_rdy[g];
        assign s_rdy[g]          = src_if[g].req_rdy;
        assign s_rsp_vld[g]      = src_if[g].rsp_vld;
        assign s_rsp_pkt[g]      = src_if[g].rsp_pkt;
    end

    typedef struct {
        int          owner;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        ldst_req_t pkt;
        int        cyc;
    } pend_t;

    exp_t  exp_q [$];
    pend_t pend_q [$];
    int    mon_q [$];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    int p_vld [N_REQ];
    int p_grdy;
    int p_rsp;
    int p_srdy;
    bit fixed_addr;

    int m_ptr  = 0;
    int m_lock = -1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit roll(input int p);
        return (int'($urandom_range(99)) < p);
    endfunction

    // Downstream memory contents as a pure function of the request.
    function automatic logic [31:0] mem_rd(input ldst_req_t r);
        return (r.addr * 32'h9E37_79B1) ^ {r.wdata[15:0], r.wdata[31:16]} ^ {31'b0, r.we};
    endfunction

    task automatic new_req(input int i);
        s_vld[i]       = 1'b1;
        s_pkt[i].addr  = fixed_addr ? 32'h100 : $urandom;
        s_pkt[i].wdata = $urandom;
        s_pkt[i].be    = 4'($urandom);
        s_pkt[i].we    = 1'($urandom);
    endtask

    // Requesters and downstream: observe handshakes at negedge, drive after posedge.
    task automatic run_cycles(input int n);
        logic [N_REQ-1:0] acc;
        bit               rsp_done;
        repeat (n) begin
            @(negedge clk);
            acc      = '0;
            rsp_done = 1'b0;
            if (!rst) begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (s_vld[i] && s_rdy[i]) begin
                        acc[i] = 1'b1;
                        exp_q.push_back('{owner: i, rdata: mem_rd(s_pkt[i])});
                    end
                end
                if (gen_if.req_vld && gen_if.req_rdy) begin
                    pend_q.push_back('{pkt: gen_if.req_pkt, cyc: cyc});
                end
                if (gen_if.rsp_vld && gen_if.rsp_rdy) begin
                    rsp_done = 1'b1;
                    if (pend_q.size() > 0) void'(pend_q.pop_front());
                end
            end
            @(posedge clk);
            cyc++;
            #1;
            for (int i = 0; i < N_REQ; i++) begin
                if (acc[i] || !s_vld[i]) begin
                    if (roll(p_vld[i])) new_req(i);
                    else s_vld[i] = 1'b0;
                end
                s_rsp_rdy[i] = roll(p_srdy);
            end
            gen_if.req_rdy = roll(p_grdy);
            if (rsp_done) gen_if.rsp_vld = 1'b0;
            if (!gen_if.rsp_vld && pend_q.size() > 0 && pend_q[0].cyc < cyc && roll(p_rsp)) begin
                gen_if.rsp_vld = 1'b1;
                gen_if.rsp_pkt = '{rdata: mem_rd(pend_q[0].pkt), err: 1'b0};
            end
        end
    endtask

    // Reference arbiter + response scoreboard, sampled at negedge.
    initial begin
        int               cnt;
        int               owner;
        int               head;
        bit               issue;
        logic [N_REQ-1:0] exp_rdy;
        logic [N_REQ-1:0] exp_rv;
        logic             exp_grdy;
        exp_t             e;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_ptr  = 0;
                m_lock = -1;
                mon_q.delete();
            end else begin
                cnt   = mon_q.size();
                owner = m_lock;
                if (owner < 0) begin
                    for (int k = 0; k < N_REQ; k++) begin
                        if (owner < 0 && s_vld[(m_ptr + k) % N_REQ]) owner = (m_ptr + k) % N_REQ;
                    end
                end
                issue   = (owner >= 0) && (cnt < MAX_OUT);
                exp_rdy = '0;
                if (issue && gen_if.req_rdy) exp_rdy[owner] = 1'b1;
                check("gen_req_vld", 128'(gen_if.req_vld), 128'(issue));
                check("src_req_rdy", 128'(s_rdy), 128'(exp_rdy));
                if (issue) check("gen_req_pkt", 128'(gen_if.req_pkt), 128'(s_pkt[owner]));

                exp_rv   = '0;
                exp_grdy = 1'b0;
                head     = 0;
                if (cnt > 0) begin
                    head         = mon_q[0];
                    exp_rv[head] = gen_if.rsp_vld;
                    exp_grdy     = s_rsp_rdy[head];
                end
                check("src_rsp_vld", 128'(s_rsp_vld), 128'(exp_rv));
                check("gen_rsp_rdy", 128'(gen_if.rsp_rdy), 128'(exp_grdy));
                if (cnt > 0 && gen_if.rsp_vld && s_rsp_rdy[head]) begin
                    check("rsp_expected", 128'(exp_q.size() > 0), 128'(1));
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("rsp_owner", 128'(head), 128'(e.owner));
                        check("rsp_rdata", 128'(s_rsp_pkt[head].rdata), 128'(e.rdata));
                    end
                    void'(mon_q.pop_front());
                end

                if (issue && gen_if.req_rdy) begin
                    mon_q.push_back(owner);
                    m_ptr  = (owner + 1) % N_REQ;
                    m_lock = -1;
                end else if (issue) begin
                    m_lock = owner;
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gen_req_vld"}, 128'(gen_if.req_vld), 128'(0));
        check({tag, "_gen_rsp_rdy"}, 128'(gen_if.rsp_rdy), 128'(0));
        check({tag, "_src_req_rdy"}, 128'(s_rdy), 128'(0));
        check({tag, "_src_rsp_vld"}, 128'(s_rsp_vld), 128'(0));
    endtask

    task automatic set_knobs(input int v0, input int v1, input int grdy, input int rsp, input int srdy);
        p_vld[0] = v0;
        p_vld[1] = v1;
        p_grdy   = grdy;
        p_rsp    = rsp;
        p_srdy   = srdy;
    endtask

    initial begin
        s_vld          = '0;
        s_rsp_rdy      = '0;
        fixed_addr     = 1'b0;
        gen_if.req_rdy = 1'b0;
        gen_if.rsp_vld = 1'b0;
        gen_if.rsp_pkt = '0;
        for (int i = 0; i < N_REQ; i++) s_pkt[i] = '0;
        set_knobs(0, 0, 0, 0, 0);

        // Reset holds all handshake outputs low even with live inputs.
        s_vld          = '1;
        s_rsp_rdy      = '1;
        gen_if.req_rdy = 1'b1;
        #1;
        check_reset_outputs("reset");
        s_vld          = '0;
        s_rsp_rdy      = '0;
        gen_if.req_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single requester at address 0x100.
        fixed_addr = 1'b1;
        set_knobs(0, 100, 100, 100, 100);
        run_cycles(12);
        fixed_addr = 1'b0;

        // Both requesters always valid: grants alternate.
        set_knobs(100, 100, 100, 100, 100);
        run_cycles(30);

        // Downstream back-pressure exercises the lock.
        set_knobs(100, 80, 30, 60, 80);
        run_cycles(40);

        // Fill to the outstanding limit, then release responses.
        set_knobs(100, 100, 100, 0, 100);
        run_cycles(12);
        set_knobs(100, 100, 100, 100, 100);
        run_cycles(20);

        // Mixed random traffic.
        set_knobs(60, 60, 60, 60, 70);
        run_cycles(600);

        // Build up outstanding requests and a lock, then reset mid-cycle.
        set_knobs(100, 100, 100, 0, 100);
        run_cycles(3);
        set_knobs(100, 100, 0, 0, 100);
        run_cycles(2);
        @(posedge clk);
        #1;
        for (int i = 0; i < N_REQ; i++) if (!s_vld[i]) new_req(i);
        s_rsp_rdy      = '1;
        gen_if.req_rdy = 1'b1;
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        s_vld          = '0;
        gen_if.req_rdy = 1'b0;
        gen_if.rsp_vld = 1'b0;
        exp_q.delete();
        pend_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // After reset only the second requester asks.
        set_knobs(0, 100, 100, 100, 100);
        run_cycles(10);

        // Drain: every expected response must come back within the budget.
        set_knobs(0, 0, 100, 100, 100);
        run_cycles(30);
        check("drain_exp_q", 128'(exp_q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
